// File: rtl/sync_ram.sv
// sync_ram: parametrised single-port synchronous RAM with a registered read port,
// a one-cycle valid strobe, selectable read-during-write behaviour and an
// optional reset-triggered clear sequence that zeroes every word.
module sync_ram #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter bit RDW_MODE       = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] in,
  input  logic              rd_,
  input  logic              wr_,
  output logic [DATA_W-1:0] out,
  output logic              valid,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   rd_word;

  // Current contents at the access address; this is the "old" data for read-first.
  assign rd_word = mem[addr];

  // Next-state, read-data and write-port selection; reset gates off any write.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = in;
    if (!rst) begin
      unique case (state_q)
        ST_CLEAR: begin
          // Accesses are locked out; one word is zeroed per edge.
          mem_we    = 1'b1;
          mem_waddr = clr_cnt_q;
          mem_wdata = '0;
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (&clr_cnt_q) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
        ST_IDLE: begin
          if (!wr_) begin
            mem_we = 1'b1;
          end
          if (!rd_) begin
            valid_d = 1'b1;
            // Same-edge write: write-first forwards the incoming word.
            if (!wr_ && !RDW_MODE) begin
              out_d = in;
            end else begin
              out_d = rd_word;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control and read-port registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_cnt_q <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= CLEAR_ON_RESET;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  // Storage array write port, shared by the clear sequencer and normal writes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_sync_ram.sv
// tb_sync_ram: drives three sync_ram instances (8x256 write-first, 8x256
// read-first, 16x16 without clear) with one shared stimulus stream; a
// behavioural model predicts each edge's outcome into a queue that a
// negedge monitor pops and compares.
module tb_sync_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  addr = '0;
  logic [15:0] din = '0;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;

  logic [7:0]  out_a, out_b;
  logic [15:0] out_c;
  logic        valid_a, valid_b, valid_c;
  logic        busy_a, busy_b, busy_c;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  sync_ram #(.DATA_W(8), .ADDR_W(8), .CLEAR_ON_RESET(1'b1), .RDW_MODE(1'b0)) u_a (
    .clk(clk), .rst(rst), .addr(addr), .in(din[7:0]), .rd_(rd_n), .wr_(wr_n),
    .out(out_a), .valid(valid_a), .busy(busy_a));

  sync_ram #(.DATA_W(8), .ADDR_W(8), .CLEAR_ON_RESET(1'b1), .RDW_MODE(1'b1)) u_b (
    .clk(clk), .rst(rst), .addr(addr), .in(din[7:0]), .rd_(rd_n), .wr_(wr_n),
    .out(out_b), .valid(valid_b), .busy(busy_b));

  sync_ram #(.DATA_W(16), .ADDR_W(4), .CLEAR_ON_RESET(1'b0), .RDW_MODE(1'b0)) u_c (
    .clk(clk), .rst(rst), .addr(addr[3:0]), .in(din), .rd_(rd_n), .wr_(wr_n),
    .out(out_c), .valid(valid_c), .busy(busy_c));

  // Expected observable result after one clock edge.
  typedef struct {
    bit          busy;   // busy of the clearing instances
    bit          va;     // valid expected on the 8x256 instances
    logic [7:0]  da;     // write-first data
    logic [7:0]  db;     // read-first data
    bit          vc;
    bit          kc;     // data of the 16x16 instance is defined
    logic [15:0] dc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [7:0]  mem_ab [256];
  logic [15:0] mem_c  [16];
  bit          known_c [16];
  int          clr_left = 0;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    else n_pass++;
  endtask

  // Apply one cycle of stimulus, predict its result, and advance past the edge.
  task automatic step(input bit r_rst, input bit r_rd, input bit r_wr,
                      input logic [7:0] a, input logic [15:0] d);
    exp_t e;
    logic [7:0]  old;
    logic [15:0] old_c;
    bit          kold;
    rst = r_rst; rd_n = r_rd; wr_n = r_wr; addr = a; din = d;
    e = '{default: '0};
    if (r_rst) begin
      clr_left = 256;
    end else if (clr_left > 0) begin
      mem_ab[256 - clr_left] = 8'h00;
      clr_left--;
    end else begin
      old = mem_ab[a];
      if (!r_wr) mem_ab[a] = d[7:0];
      if (!r_rd) begin
        e.va = 1'b1;
        e.da = !r_wr ? d[7:0] : old;
        e.db = old;
      end
    end
    e.busy = (clr_left > 0);
    if (!r_rst) begin
      old_c = mem_c[a[3:0]];
      kold  = known_c[a[3:0]];
      if (!r_wr) begin
        mem_c[a[3:0]]   = d;
        known_c[a[3:0]] = 1'b1;
      end
      if (!r_rd) begin
        e.vc = 1'b1;
        e.kc = !r_wr || kold;
        e.dc = !r_wr ? d : old_c;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 8'h00, 16'h0000);
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    step(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [7:0] a);
    step(1'b0, 1'b0, 1'b1, a, 16'h0000);
  endtask

  // Monitor: one expectation per edge, compared half a cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("busy_a", {15'd0, busy_a}, {15'd0, e.busy});
      chk("busy_b", {15'd0, busy_b}, {15'd0, e.busy});
      chk("busy_c", {15'd0, busy_c}, 16'h0000);
      chk("valid_a", {15'd0, valid_a}, {15'd0, e.va});
      chk("valid_b", {15'd0, valid_b}, {15'd0, e.va});
      chk("valid_c", {15'd0, valid_c}, {15'd0, e.vc});
      if (e.va && valid_a) chk("out_a", {8'd0, out_a}, {8'd0, e.da});
      if (e.va && valid_b) chk("out_b", {8'd0, out_b}, {8'd0, e.db});
      if (e.vc && e.kc && valid_c) chk("out_c", out_c, e.dc);
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_ab[i] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      mem_c[i]   = 16'h0000;
      known_c[i] = 1'b0;
    end

    // Clear after reset, with write/read attempts locked out during the clear.
    step(1'b1, 1'b1, 1'b1, 8'h00, 16'h0000);
    chk("rst_out_a", {8'd0, out_a}, 16'h0000);
    chk("rst_valid_a", {15'd0, valid_a}, 16'h0000);
    chk("rst_busy_a", {15'd0, busy_a}, 16'h0001);
    chk("rst_out_c", out_c, 16'h0000);
    idle(10);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 8'hF0, 16'h0055);
    idle(236);
    rd(8'h00); idle(1);
    rd(8'h7F); idle(1);
    rd(8'hFF); idle(1);
    rd(8'hF0); idle(1);

    // Write then back-to-back reads.
    wr(8'h10, 16'h00A5);
    wr(8'hFF, 16'h003C);
    rd(8'h10);
    rd(8'hFF);
    idle(2);

    // Read-during-write.
    wr(8'h20, 16'h0011);
    step(1'b0, 1'b0, 1'b0, 8'h20, 16'h0099);
    idle(1);
    rd(8'h20);
    idle(1);

    // Reset mid-clear restarts the full clear.
    wr(8'h33, 16'h00C7);
    rd(8'h33);
    step(1'b1, 1'b1, 1'b1, 8'h00, 16'h0000);
    chk("rst2_out_a", {8'd0, out_a}, 16'h0000);
    idle(99);
    step(1'b1, 1'b0, 1'b0, 8'h05, 16'h0077);
    chk("midclr_out_a", {8'd0, out_a}, 16'h0000);
    chk("midclr_out_b", {8'd0, out_b}, 16'h0000);
    chk("midclr_valid_a", {15'd0, valid_a}, 16'h0000);
    idle(256);
    for (int i = 0; i < 256; i++) rd(8'(i));
    idle(1);

    // Wide/no-clear instance: contents survive reset.
    wr(8'h0F, 16'hBEEF);
    rd(8'h0F);
    idle(1);
    step(1'b1, 1'b1, 1'b1, 8'h00, 16'h0000);
    rd(8'h0F);
    idle(1);
    chk("c_keep_beef", out_c, 16'hBEEF);
    idle(256);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 16'($urandom));
    end
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 3)), 16'($urandom));
    end
    idle(2);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sync_ram.md
# sync_ram

Parametrised single-port synchronous RAM and the successor to the 8x256 combinational-read memory. Width and depth are set by parameters. Reads are registered with a one-cycle `valid` strobe, and read-during-write behaviour is selectable. A reset-triggered clear sequencer zeroes the whole array before the block accepts accesses. It sits on the CPU data/instruction memory bus and keeps the active-low `rd_`/`wr_` strobe semantics.

## Interface
- `DATA_W`, default 8: word width in bits.
- `ADDR_W`, default 8: address width; depth `DEPTH = 2**ADDR_W` words.
- `CLEAR_ON_RESET`, default 1: 1 = zero every word after reset; 0 = skip clearing, contents undefined.
- `RDW_MODE`, default 0: same-address read and write in one cycle; 0 = write-first (read returns new data), 1 = read-first (read returns old data).

- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `addr`  in  `ADDR_W`  word address for read/write.
- `in`  in  `DATA_W`  write data.
- `rd_`  in  1  read enable, active low.
- `wr_`  in  1  write enable, active low.
- `out`  out  `DATA_W`  registered read data; holds until the next accepted read.
- `valid`  out  1  one-cycle pulse: `out` updated by the read accepted on the previous edge.
- `busy`  out  1  high while the clear sequence runs; accesses ignored.

## Operation
- Two states: CLEAR and IDLE.
- On an edge with `rst`=1:
  - State goes to CLEAR if `CLEAR_ON_RESET`=1, else IDLE.
  - Clear counter `clr_cnt` goes to 0.
  - `out` goes to 0 and `valid` goes to 0.
  - `busy` goes to `CLEAR_ON_RESET`.
  - Any `rd_`/`wr_` presented on that edge is discarded.
  - `rst` overrides everything and may assert in any state.
- CLEAR state:
  - Each edge writes 0 to `mem[clr_cnt]` and increments `clr_cnt`.
  - On the edge that writes word `DEPTH-1`: state goes to IDLE, `busy` goes to 0, `clr_cnt` wraps to 0.
  - `rd_`/`wr_` are ignored and `valid` stays 0.
- IDLE state, writes: `wr_`=0 at an edge writes `mem[addr] <= in`.
- IDLE state, reads: `rd_`=0 at an edge loads `out <= mem[addr]` and sets `valid` to 1 for the following cycle.
  - `rd_`=1 clears `valid` to 0 and leaves `out` unchanged.
- Both `rd_`=0 and `wr_`=0 on the same edge: both operations happen, which is legal.
  - `RDW_MODE`=0: `out` gets `in`.
  - `RDW_MODE`=1: `out` gets the prior `mem[addr]`.
- Addresses are full-range, so there is no out-of-range case. `addr` and `in` are don't-care when their strobes are high.
- Reset mid-clear restarts the clear from word 0. Reset mid-IDLE drops the access in flight on that edge; earlier writes persist if `CLEAR_ON_RESET`=0.

## Timing
- Read latency is 1 cycle: strobe sampled at edge N; `out` and `valid` valid after edge N, for cycle N+1.
- Write latency is 0 for a subsequent read: a write at edge N is visible to a read at edge N+1.
- Back-to-back reads every cycle are supported. `valid` stays high continuously and `out` changes each cycle.
- Clear duration: reset sampled at edge R, so words 0..`DEPTH-1` are written at edges R+1..R+`DEPTH`.
  - `busy` is high from after R until after R+`DEPTH`.
  - The first accepted access is at edge R+`DEPTH`+1.
- With `CLEAR_ON_RESET`=0, `busy` stays 0 and accesses are accepted from edge R+1.
- Reset values: `out`=0, `valid`=0, `busy`=`CLEAR_ON_RESET`.

## Test plan
- Clear and readback: defaults; hold `rst` for 1 edge, then release.
  - `busy` is high for exactly 256 cycles.
  - Reading addresses 0x00, 0x7F and 0xFF then gives `out`=0x00 with a single `valid` pulse each.
- Write/read: write 0xA5 to 0x10, then 0x3C to 0xFF, then read 0x10 and 0xFF back-to-back.
  - `out` is 0xA5 then 0x3C.
  - `valid` is high for 2 consecutive cycles, then low.
- Read-during-write: preload 0x20=0x11, then `rd_`=`wr_`=0 at 0x20 with `in`=0x99.
  - `RDW_MODE`=0 gives `out`=0x99.
  - `RDW_MODE`=1 gives `out`=0x11.
  - In both cases a later read of 0x20 gives 0x99.
- Busy lockout: during clear, drive `wr_`=0 at address 0xF0 (not yet cleared) with `in`=0x55, and `rd_`=0.
  - `valid` stays 0.
  - After clear, a read of 0xF0 gives 0x00.
- Reset mid-clear: assert `rst` at clear cycle 100.
  - `out`/`valid` go to 0.
  - `busy` then stays high for a further full 256 cycles.
  - All words read 0.
- Parametrisation and no-clear: `DATA_W`=16, `ADDR_W`=4, `CLEAR_ON_RESET`=0.
  - `busy` is never high.
  - Write 0xBEEF to 0xF and read it back, giving 0xBEEF.
  - Reset then read 0xF: `out` is still 0xBEEF.
